// File: rtl/tree_cmp_pkg.sv
// Shared types and elaboration-time helpers for the arg-min/arg-max class tree.
package tree_cmp_pkg;

  typedef enum logic {MODE_MIN, MODE_MAX} cmp_mode_t;

  // A tree over n leaves has ceil(log2(n)) levels, and a single class has none.
  function automatic int f_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int f_latency(input int n, input int reg_every);
    int lat;
    lat = (f_levels(n) + reg_every - 1) / reg_every;
    return (lat < 1) ? 1 : lat;
  endfunction

  function automatic int f_class_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Number of operands entering tree level l.
  function automatic int f_count(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/argext_node.sv
// One compare/select node: picks the left or right (value, index, tie) tuple.
module argext_node
  import tree_cmp_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int CLASS_W    = 3,
  parameter int SIGNED     = 0
) (
  input  cmp_mode_t              i_mode,
  input  logic [WIDTH_DATA-1:0]  i_vl,
  input  logic [CLASS_W-1:0]     i_il,
  input  logic                   i_tl,
  input  logic [WIDTH_DATA-1:0]  i_vr,
  input  logic [CLASS_W-1:0]     i_ir,
  input  logic                   i_tr,
  output logic [WIDTH_DATA-1:0]  o_v,
  output logic [CLASS_W-1:0]     o_i,
  output logic                   o_t
);

  logic w_lt;
  logic w_eq;
  logic w_left;

  assign w_lt = (SIGNED != 0) ? ($signed(i_vl) < $signed(i_vr)) : (i_vl < i_vr);
  assign w_eq = (i_vl == i_vr);

  // Left always carries the lower index, so equality resolves to the left.
  assign w_left = (i_mode == MODE_MAX) ? ~w_lt : (w_lt | w_eq);

  assign o_v = w_left ? i_vl : i_vr;
  assign o_i = w_left ? i_il : i_ir;
  assign o_t = w_eq | (w_left ? i_tl : i_tr);

endmodule

// File: rtl/argext_tree_pipe.sv
// Streaming, pipelined arg-min/arg-max over AMOUNT_CLASS scores with a tie flag.
// Handshake: a beat moves when valid & ready are both high at a rising edge; out_* hold while out_valid & ~out_ready.
module argext_tree_pipe
  import tree_cmp_pkg::*;
#(
  parameter int WIDTH_DATA   = 8,
  parameter int AMOUNT_CLASS = 5,
  parameter int REG_EVERY    = 1,
  parameter int SIGNED       = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_mode,
  input  logic [AMOUNT_CLASS-1:0][WIDTH_DATA-1:0]  in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [f_class_w(AMOUNT_CLASS)-1:0]       out_class,
  output logic [WIDTH_DATA-1:0]                    out_data,
  output logic                                     out_tie
);

  localparam int CLASS_W = f_class_w(AMOUNT_CLASS);
  localparam int LEVELS  = f_levels(AMOUNT_CLASS);

  typedef logic [WIDTH_DATA-1:0] val_t;
  typedef logic [CLASS_W-1:0]    idx_t;

  // Level l operands; index LEVELS is what the output register captures.
  val_t      w_val  [LEVELS+1][AMOUNT_CLASS];
  idx_t      w_idx  [LEVELS+1][AMOUNT_CLASS];
  logic      w_tie  [LEVELS+1][AMOUNT_CLASS];
  cmp_mode_t w_mode [LEVELS+1];
  logic      w_vld  [LEVELS+1];
  logic      w_adv;

  logic      r_out_valid;
  idx_t      r_out_class;
  val_t      r_out_data;
  logic      r_out_tie;

  assign w_adv    = out_ready | ~r_out_valid;
  assign in_ready = w_adv & rst_n;

  assign w_mode[0] = cmp_mode_t'(in_mode);
  assign w_vld[0]  = in_valid & in_ready;

  for (genvar k = 0; k < AMOUNT_CLASS; k++) begin : g_leaf
    assign w_val[0][k] = in_data[k];
    assign w_idx[0][k] = CLASS_W'(k);
    assign w_tie[0][k] = 1'b0;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int CNT = f_count(AMOUNT_CLASS, l);
    val_t c_val [AMOUNT_CLASS];
    idx_t c_idx [AMOUNT_CLASS];
    logic c_tie [AMOUNT_CLASS];

    for (genvar k = 0; k < AMOUNT_CLASS; k++) begin : g_slot
      if (k < CNT / 2) begin : g_node
        argext_node #(
          .WIDTH_DATA (WIDTH_DATA),
          .CLASS_W    (CLASS_W),
          .SIGNED     (SIGNED)
        ) u_node (
          .i_mode (w_mode[l]),
          .i_vl   (w_val[l][2*k]),
          .i_il   (w_idx[l][2*k]),
          .i_tl   (w_tie[l][2*k]),
          .i_vr   (w_val[l][2*k+1]),
          .i_ir   (w_idx[l][2*k+1]),
          .i_tr   (w_tie[l][2*k+1]),
          .o_v    (c_val[k]),
          .o_i    (c_idx[k]),
          .o_t    (c_tie[k])
        );
      end else if ((k == CNT / 2) && (CNT % 2 == 1)) begin : g_pass
        assign c_val[k] = w_val[l][2*k];
        assign c_idx[k] = w_idx[l][2*k];
        assign c_tie[k] = w_tie[l][2*k];
      end else begin : g_idle
        assign c_val[k] = '0;
        assign c_idx[k] = '0;
        assign c_tie[k] = 1'b0;
      end
    end

    // The last level always lands in the output register, never a mid stage.
    if ((l % REG_EVERY == REG_EVERY - 1) && (l < LEVELS - 1)) begin : g_reg
      val_t      r_val [AMOUNT_CLASS];
      idx_t      r_idx [AMOUNT_CLASS];
      logic      r_tie [AMOUNT_CLASS];
      cmp_mode_t r_mode;
      logic      r_vld;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
        end else if (w_adv) begin
          r_vld  <= w_vld[l];
          r_mode <= w_mode[l];
          r_val  <= c_val;
          r_idx  <= c_idx;
          r_tie  <= c_tie;
        end
      end

      assign w_vld[l+1]  = r_vld;
      assign w_mode[l+1] = r_mode;
      for (genvar k = 0; k < AMOUNT_CLASS; k++) begin : g_fwd
        assign w_val[l+1][k] = r_val[k];
        assign w_idx[l+1][k] = r_idx[k];
        assign w_tie[l+1][k] = r_tie[k];
      end
    end else begin : g_cmb
      assign w_vld[l+1]  = w_vld[l];
      assign w_mode[l+1] = w_mode[l];
      for (genvar k = 0; k < AMOUNT_CLASS; k++) begin : g_fwd
        assign w_val[l+1][k] = c_val[k];
        assign w_idx[l+1][k] = c_idx[k];
        assign w_tie[l+1][k] = c_tie[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_data  <= '0;
      r_out_tie   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_vld[LEVELS];
      if (w_vld[LEVELS]) begin
        r_out_class <= w_idx[LEVELS][0];
        r_out_data  <= w_val[LEVELS][0];
        r_out_tie   <= w_tie[LEVELS][0];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_data  = r_out_data;
  assign out_tie   = r_out_tie;

endmodule

// File: tb/tb_argext_tree_pipe.sv
// Bench for argext_tree_pipe: default, signed, single-class and 8-class/REG_EVERY=2 instances.
module tb_argext_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // dut0: defaults (N=5, unsigned, REG_EVERY=1)
  logic            in_valid0 = 0, in_ready0, in_mode0 = 0, out_valid0, out_ready0 = 1, out_tie0;
  logic [4:0][7:0] in_data0 = '0;
  logic [2:0]      out_class0;
  logic [7:0]      out_data0;
  // dut1: SIGNED=1
  logic            in_valid1 = 0, in_ready1, in_mode1 = 0, out_valid1, out_ready1 = 1, out_tie1;
  logic [4:0][7:0] in_data1 = '0;
  logic [2:0]      out_class1;
  logic [7:0]      out_data1;
  // dut2: N=1, REG_EVERY=2
  logic            in_valid2 = 0, in_ready2, in_mode2 = 0, out_valid2, out_ready2 = 1, out_tie2;
  logic [0:0][7:0] in_data2 = '0;
  logic [0:0]      out_class2;
  logic [7:0]      out_data2;
  // dut3: N=8, REG_EVERY=2
  logic            in_valid3 = 0, in_ready3, in_mode3 = 0, out_valid3, out_ready3 = 1, out_tie3;
  logic [7:0][7:0] in_data3 = '0;
  logic [2:0]      out_class3;
  logic [7:0]      out_data3;

  argext_tree_pipe u_dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_mode(in_mode0), .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_class(out_class0), .out_data(out_data0), .out_tie(out_tie0));
  argext_tree_pipe #(.SIGNED(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
    .in_ready(in_ready1), .in_mode(in_mode1), .in_data(in_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_class(out_class1), .out_data(out_data1), .out_tie(out_tie1));
  argext_tree_pipe #(.AMOUNT_CLASS(1), .REG_EVERY(2)) u_dut2 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_mode(in_mode2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_class(out_class2), .out_data(out_data2),
    .out_tie(out_tie2));
  argext_tree_pipe #(.AMOUNT_CLASS(8), .REG_EVERY(2)) u_dut3 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_mode(in_mode3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_class(out_class3), .out_data(out_data3),
    .out_tie(out_tie3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: linear scan for the first extreme score, tie when it occurs more than once.
  function automatic logic [11:0] ref_model(input logic [63:0] flat, input int n, input bit mode,
                                            input bit sgn);
    int v[8];
    int best;
    int cnt;
    for (int i = 0; i < n; i++)
      v[i] = sgn ? int'($signed(flat[i*8 +: 8])) : int'(flat[i*8 +: 8]);
    best = 0;
    for (int i = 1; i < n; i++)
      if (mode ? (v[i] > v[best]) : (v[i] < v[best])) best = i;
    cnt = 0;
    for (int i = 0; i < n; i++)
      if (v[i] == v[best]) cnt++;
    return {3'(best), 8'(v[best]), (cnt >= 2)};
  endfunction

  // Drivers: present one vector, then count edges from acceptance until out_valid.
  task automatic send0(input bit mode, input logic [4:0][7:0] d, output int lat);
    in_mode0 = mode; in_data0 = d; in_valid0 = 1; out_ready0 = 1;
    step(); in_valid0 = 0; lat = 1;
    while (!out_valid0 && lat < 12) begin step(); lat++; end
  endtask

  task automatic send1(input bit mode, input logic [4:0][7:0] d, output int lat);
    in_mode1 = mode; in_data1 = d; in_valid1 = 1;
    step(); in_valid1 = 0; lat = 1;
    while (!out_valid1 && lat < 12) begin step(); lat++; end
  endtask

  task automatic send2(input bit mode, input logic [0:0][7:0] d, output int lat);
    in_mode2 = mode; in_data2 = d; in_valid2 = 1;
    step(); in_valid2 = 0; lat = 1;
    while (!out_valid2 && lat < 12) begin step(); lat++; end
  endtask

  task automatic send3(input bit mode, input logic [7:0][7:0] d, output int lat);
    in_mode3 = mode; in_data3 = d; in_valid3 = 1;
    step(); in_valid3 = 0; lat = 1;
    while (!out_valid3 && lat < 12) begin step(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) step();
    n_cmp++;
    if ({out_valid0, out_class0, out_data0, out_tie0} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_out0: got %h want 0", {out_valid0, out_class0, out_data0, out_tie0});
    end
    n_cmp++;
    if ({in_ready0, in_ready1, in_ready2, in_ready3} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 0000", {in_ready0, in_ready1, in_ready2, in_ready3});
    end
    n_cmp++;
    if ({out_valid1, out_valid2, out_valid3} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 000", {out_valid1, out_valid2, out_valid3});
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_directed();
    int lat;
    send0(1'b0, {8'd5, 8'd3, 8'd7, 8'd3, 8'd9}, lat);
    n_cmp++;
    if (lat !== 3 || {out_class0, out_data0, out_tie0} !== {3'd1, 8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL min_tie: lat %0d cls %0d dat %0d tie %0d, want lat 3 cls 1 dat 3 tie 1",
               lat, out_class0, out_data0, out_tie0);
    end
    send0(1'b1, {8'd200, 8'd3, 8'd7, 8'd3, 8'd9}, lat);
    n_cmp++;
    if (lat !== 3 || {out_class0, out_data0, out_tie0} !== {3'd4, 8'd200, 1'b0}) begin
      n_fail++;
      $display("FAIL max_last: lat %0d cls %0d dat %0d tie %0d, want lat 3 cls 4 dat 200 tie 0",
               lat, out_class0, out_data0, out_tie0);
    end
    send0(1'b0, {5{8'd66}}, lat);
    n_cmp++;
    if ({out_class0, out_data0, out_tie0} !== {3'd0, 8'd66, 1'b1}) begin
      n_fail++;
      $display("FAIL all_equal_min: cls %0d dat %0d tie %0d, want cls 0 dat 66 tie 1",
               out_class0, out_data0, out_tie0);
    end
    send0(1'b1, {5{8'd255}}, lat);
    n_cmp++;
    if ({out_class0, out_data0, out_tie0} !== {3'd0, 8'd255, 1'b1}) begin
      n_fail++;
      $display("FAIL all_equal_max: cls %0d dat %0d tie %0d, want cls 0 dat 255 tie 1",
               out_class0, out_data0, out_tie0);
    end
    step();
  endtask

  task automatic test_signed();
    int lat;
    send1(1'b0, {8'd5, 8'd0, 8'd2, 8'hFF, 8'd1}, lat);
    n_cmp++;
    if (lat !== 3 || {out_class1, out_data1, out_tie1} !== {3'd1, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL signed_min: lat %0d cls %0d dat %h tie %0d, want lat 3 cls 1 dat ff tie 0",
               lat, out_class1, out_data1, out_tie1);
    end
    send1(1'b1, {8'h80, 8'hFF, 8'h7F, 8'h80, 8'h7F}, lat);
    n_cmp++;
    if ({out_class1, out_data1, out_tie1} !== {3'd0, 8'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL signed_max: cls %0d dat %h tie %0d, want cls 0 dat 7f tie 1",
               out_class1, out_data1, out_tie1);
    end
    step();
  endtask

  task automatic test_configs();
    int lat;
    logic [7:0][7:0] d;
    logic [11:0] exp;
    send2(1'b1, 8'h5A, lat);
    n_cmp++;
    if (lat !== 1 || {out_class2, out_data2, out_tie2} !== {1'b0, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL single_class: lat %0d cls %0d dat %h tie %0d, want lat 1 cls 0 dat 5a tie 0",
               lat, out_class2, out_data2, out_tie2);
    end
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) d[i] = ($urandom_range(0, 2) == 0) ? 8'd17 : 8'($urandom);
      exp = ref_model(64'(d), 8, t[0], 1'b0);
      send3(t[0], d, lat);
      n_cmp++;
      if (lat !== 2 || {out_class3, out_data3, out_tie3} !== exp) begin
        n_fail++;
        $display("FAIL eight_class[%0d]: lat %0d got %h, want lat 2 %h", t, lat,
                 {out_class3, out_data3, out_tie3}, exp);
      end
    end
    send3(1'b0, {8{8'h40}}, lat);
    n_cmp++;
    if ({out_class3, out_data3, out_tie3} !== {3'd0, 8'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL eight_equal: got %h want %h", {out_class3, out_data3, out_tie3},
               {3'd0, 8'h40, 1'b1});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q[$];
    logic [11:0] exp;
    logic [12:0] held;
    bit held_v = 0, last_acc = 0, acc, del, mode = 1;
    int sent = 0, recv = 0, cyc = 0;
    while ((sent < 20 || exp_q.size() > 0) && cyc < 600) begin
      if (!in_valid0 || last_acc) begin
        in_valid0 = (sent < 20) && ($urandom_range(0, 3) != 0);
        if (in_valid0) begin
          mode = ~mode;
          in_mode0 = mode;
          for (int i = 0; i < 5; i++) in_data0[i] = ($urandom_range(0, 2) == 0) ? 8'd9 : 8'($urandom);
        end
      end
      out_ready0 = $urandom_range(0, 1);
      #3;
      if (held_v) begin
        n_cmp++;
        if ({out_valid0, out_class0, out_data0, out_tie0} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got %h want %h", {out_valid0, out_class0, out_data0, out_tie0}, held);
        end
      end
      acc = in_valid0 & in_ready0;
      del = out_valid0 & out_ready0;
      if (acc) begin
        exp_q.push_back(ref_model(64'(in_data0), 5, in_mode0, 1'b0));
        sent++;
      end
      if (del) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got %h want nothing", {out_class0, out_data0, out_tie0});
        end else begin
          exp = exp_q.pop_front();
          if ({out_class0, out_data0, out_tie0} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got %h want %h", recv, {out_class0, out_data0, out_tie0}, exp);
          end
        end
        recv++;
      end
      held_v = out_valid0 & ~out_ready0;
      held = {out_valid0, out_class0, out_data0, out_tie0};
      last_acc = acc;
      step();
      cyc++;
    end
    in_valid0 = 0;
    out_ready0 = 1;
    n_cmp++;
    if (sent !== 20 || recv !== 20 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: sent %0d recv %0d left %0d, want 20 20 0", sent, recv, exp_q.size());
    end
    step();
  endtask

  task automatic test_reset_inflight();
    int lat;
    bit seen = 0;
    logic [4:0][7:0] d;
    logic [11:0] exp;
    out_ready0 = 1;
    in_valid0 = 1; in_mode0 = 0; in_data0 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    step();
    in_mode0 = 1; in_data0 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
    step();
    in_valid0 = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_reset: out_valid %0d want 0", out_valid0);
    end
    repeat (6) begin
      step();
      if (out_valid0) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_dropped: result emerged %0d want 0", seen);
    end
    for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
    exp = ref_model(64'(d), 5, 1'b1, 1'b0);
    send0(1'b1, d, lat);
    n_cmp++;
    if (lat !== 3 || {out_class0, out_data0, out_tie0} !== exp) begin
      n_fail++;
      $display("FAIL post_reset: lat %0d got %h, want lat 3 %h", lat, {out_class0, out_data0, out_tie0}, exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signed();
    test_configs();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
